// File: rtl/bp_pkg.sv
// Shared branch-predictor PHT definitions: widths, counter type, reset-sweep value,
// controller state encoding and the 2-bit saturating counter helpers.
package bp_pkg;

    localparam int PHT_INDEX_WIDTH = 8;
    localparam int CTR_WIDTH       = 2;

    typedef logic [CTR_WIDTH-1:0] pht_ctr_t;

    localparam pht_ctr_t INIT_VALUE = 2'b01;

    typedef enum logic [1:0] {
        INIT  = 2'b00,
        IDLE  = 2'b01,
        WRITE = 2'b10
    } pht_state_t;

    function automatic pht_ctr_t sat_inc(input pht_ctr_t ctr);
        if (ctr == 2'b11) begin
            sat_inc = ctr;
        end else begin
            sat_inc = ctr + 2'b01;
        end
    endfunction

    function automatic pht_ctr_t sat_dec(input pht_ctr_t ctr);
        if (ctr == 2'b00) begin
            sat_dec = ctr;
        end else begin
            sat_dec = ctr - 2'b01;
        end
    endfunction

endpackage

// File: rtl/bp_pht_ctrl_if.sv
// Fetch/commit facing handshake bundle of the PHT controller.
interface bp_pht_ctrl_if #(
    parameter int INDEX_WIDTH = bp_pkg::PHT_INDEX_WIDTH,
    parameter int CTR_WIDTH   = bp_pkg::CTR_WIDTH
);
    logic                   pred_valid;
    logic [INDEX_WIDTH-1:0] pred_index;
    logic                   pred_ready;
    logic                   pred_resp_valid;
    logic                   pred_taken;
    logic [CTR_WIDTH-1:0]   pred_counter;
    logic                   upd_valid;
    logic [INDEX_WIDTH-1:0] upd_index;
    logic                   upd_taken;
    logic                   upd_ready;
    logic                   init_done;

    modport master (
        output pred_valid, pred_index, upd_valid, upd_index, upd_taken,
        input  pred_ready, pred_resp_valid, pred_taken, pred_counter, upd_ready, init_done
    );

    modport slave (
        input  pred_valid, pred_index, upd_valid, upd_index, upd_taken,
        output pred_ready, pred_resp_valid, pred_taken, pred_counter, upd_ready, init_done
    );
endinterface

// File: rtl/mp_ooo_2_port_256_entry_2_bit.sv
// Behavioural model of the OpenRAM 2-port PHT macro: port 0 read-only, port 1 read/write.
// Inputs are registered at the clock edge; the array itself has no reset.
module mp_ooo_2_port_256_entry_2_bit #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 2
) (
    input  logic                  clk0,
    input  logic                  csb0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    output logic [DATA_WIDTH-1:0] dout0,
    input  logic                  clk1,
    input  logic                  csb1,
    input  logic                  web1,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] din1,
    output logic [DATA_WIDTH-1:0] dout1
);
    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
    logic                  csb0_r;
    logic [ADDR_WIDTH-1:0] addr0_r;
    logic                  csb1_r;
    logic                  web1_r;
    logic [ADDR_WIDTH-1:0] addr1_r;
    logic [DATA_WIDTH-1:0] din1_r;

    // Port 0 input capture.
    always_ff @(posedge clk0) begin
        csb0_r  <= csb0;
        addr0_r <= addr0;
    end

    // Port 1 input capture; a registered write lands in the array on the following edge.
    always_ff @(posedge clk1) begin
        csb1_r  <= csb1;
        web1_r  <= web1;
        addr1_r <= addr1;
        din1_r  <= din1;
        if (!csb1_r && !web1_r) begin
            mem[addr1_r] <= din1_r;
        end
    end

    assign dout0 = csb0_r ? {DATA_WIDTH{1'b0}} : mem[addr0_r];
    assign dout1 = csb1_r ? {DATA_WIDTH{1'b0}} : mem[addr1_r];

endmodule

// File: rtl/bp_pht_ctrl.sv
// PHT controller: reset sweep, single-cycle predict reads on port 0 and
// read-modify-write counter updates on port 1 with write-to-read forwarding.
module bp_pht_ctrl #(
    parameter int                   INDEX_WIDTH = bp_pkg::PHT_INDEX_WIDTH,
    parameter int                   CTR_WIDTH   = bp_pkg::CTR_WIDTH,
    parameter logic [CTR_WIDTH-1:0] INIT_VALUE  = bp_pkg::INIT_VALUE
) (
    input  logic          clk,
    input  logic          rst_n,
    bp_pht_ctrl_if.slave  bus
);
    import bp_pkg::*;

    localparam logic [INDEX_WIDTH-1:0] LAST_IDX = {INDEX_WIDTH{1'b1}};
    localparam logic [INDEX_WIDTH-1:0] IDX_ONE  = {{(INDEX_WIDTH-1){1'b0}}, 1'b1};

    pht_state_t             state_r;
    pht_state_t             state_nxt_s;
    logic [INDEX_WIDTH-1:0] sweep_idx_r;
    logic [INDEX_WIDTH-1:0] upd_idx_r;
    logic                   upd_taken_r;
    logic                   pend_valid_r;
    logic [INDEX_WIDTH-1:0] pend_idx_r;
    logic [CTR_WIDTH-1:0]   pend_ctr_r;
    logic                   resp_valid_r;
    logic [INDEX_WIDTH-1:0] resp_idx_r;
    logic                   pred_ready_r;
    logic                   upd_ready_r;
    logic                   init_done_r;

    logic                   pred_accept_s;
    logic                   upd_accept_s;
    logic [INDEX_WIDTH-1:0] addr1_s;
    logic [CTR_WIDTH-1:0]   din1_s;
    logic                   web1_s;
    logic [CTR_WIDTH-1:0]   dout0_s;
    logic [CTR_WIDTH-1:0]   dout1_s;
    logic [CTR_WIDTH-1:0]   new_ctr_s;
    logic [CTR_WIDTH-1:0]   resp_ctr_s;

    assign pred_accept_s = bus.pred_valid & pred_ready_r;
    assign upd_accept_s  = bus.upd_valid & upd_ready_r;
    assign new_ctr_s     = upd_taken_r ? sat_inc(dout1_s) : sat_dec(dout1_s);

    // Next state and port-1 drive; web1 is explicit every cycle so no write repeats.
    always_comb begin
        state_nxt_s = state_r;
        addr1_s     = bus.upd_index;
        din1_s      = {CTR_WIDTH{1'b0}};
        web1_s      = 1'b1;
        case (state_r)
            INIT: begin
                addr1_s = sweep_idx_r;
                din1_s  = INIT_VALUE;
                web1_s  = 1'b0;
                if (sweep_idx_r == LAST_IDX) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = INIT;
                end
            end
            IDLE: begin
                if (upd_accept_s) begin
                    state_nxt_s = WRITE;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            WRITE: begin
                addr1_s     = upd_idx_r;
                din1_s      = new_ctr_s;
                web1_s      = 1'b0;
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = INIT;
            end
        endcase
    end

    // Controller state, sweep index, update capture and handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= INIT;
            sweep_idx_r  <= {INDEX_WIDTH{1'b0}};
            upd_idx_r    <= {INDEX_WIDTH{1'b0}};
            upd_taken_r  <= 1'b0;
            pred_ready_r <= 1'b0;
            upd_ready_r  <= 1'b0;
            init_done_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            if (state_r == INIT) begin
                sweep_idx_r <= sweep_idx_r + IDX_ONE;
            end else begin
                sweep_idx_r <= {INDEX_WIDTH{1'b0}};
            end
            if (upd_accept_s) begin
                upd_idx_r   <= bus.upd_index;
                upd_taken_r <= bus.upd_taken;
            end
            pred_ready_r <= (state_nxt_s != INIT);
            init_done_r  <= (state_nxt_s != INIT);
            upd_ready_r  <= (state_nxt_s == IDLE);
        end
    end

    // Pending-write and predict-response tracking; pending lives only for the commit cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_valid_r <= 1'b0;
            pend_idx_r   <= {INDEX_WIDTH{1'b0}};
            pend_ctr_r   <= {CTR_WIDTH{1'b0}};
            resp_valid_r <= 1'b0;
            resp_idx_r   <= {INDEX_WIDTH{1'b0}};
        end else begin
            pend_valid_r <= (state_r == WRITE);
            if (state_r == WRITE) begin
                pend_idx_r <= upd_idx_r;
                pend_ctr_r <= new_ctr_s;
            end
            resp_valid_r <= pred_accept_s;
            if (pred_accept_s) begin
                resp_idx_r <= bus.pred_index;
            end
        end
    end

    // A response coinciding with the not-yet-committed write to its index takes the new value.
    always_comb begin
        resp_ctr_s = {CTR_WIDTH{1'b0}};
        if (resp_valid_r) begin
            if (pend_valid_r && (pend_idx_r == resp_idx_r)) begin
                resp_ctr_s = pend_ctr_r;
            end else begin
                resp_ctr_s = dout0_s;
            end
        end else begin
            resp_ctr_s = {CTR_WIDTH{1'b0}};
        end
    end

    assign bus.pred_ready      = pred_ready_r;
    assign bus.upd_ready       = upd_ready_r;
    assign bus.init_done       = init_done_r;
    assign bus.pred_resp_valid = resp_valid_r;
    assign bus.pred_counter    = resp_ctr_s;
    assign bus.pred_taken      = resp_ctr_s[CTR_WIDTH-1];

    mp_ooo_2_port_256_entry_2_bit #(
        .ADDR_WIDTH (INDEX_WIDTH),
        .DATA_WIDTH (CTR_WIDTH)
    ) u_pht_sram (
        .clk0  (clk),
        .csb0  (1'b0),
        .addr0 (bus.pred_index),
        .dout0 (dout0_s),
        .clk1  (clk),
        .csb1  (1'b0),
        .web1  (web1_s),
        .addr1 (addr1_s),
        .din1  (din1_s),
        .dout1 (dout1_s)
    );

endmodule

// File: tb/tb_bp_pht_ctrl.sv
// Self-checking bench for bp_pht_ctrl against a counter-array reference model.
module tb_bp_pht_ctrl;
    logic clk;
    logic rst_n;

    bp_pht_ctrl_if #(.INDEX_WIDTH(8), .CTR_WIDTH(2)) bus ();

    bp_pht_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int         checks = 0;
    int         errors = 0;
    int         model [256];
    bit         m_ready;
    bit         m_upd_ready;
    bit         exp_rv;
    logic [1:0] exp_ctr;
    int         m_init_left;
    int         n_upd_acc;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: an update accepted in a cycle is visible to predicts accepted from the next cycle on.
    task automatic drive(input bit pv, input int pi, input bit uv, input int ui, input bit ut);
        bit uacc;
        bus.pred_valid = pv;
        bus.pred_index = pi[7:0];
        bus.upd_valid  = uv;
        bus.upd_index  = ui[7:0];
        bus.upd_taken  = ut;
        exp_rv  = pv && m_ready;
        exp_ctr = exp_rv ? 2'(model[pi]) : 2'b00;
        uacc    = uv && m_upd_ready;
        if (uacc) begin
            if (ut) model[ui] = (model[ui] >= 3) ? 3 : model[ui] + 1;
            else    model[ui] = (model[ui] <= 0) ? 0 : model[ui] - 1;
            n_upd_acc++;
        end
        @(posedge clk);
        #1;
        if (m_init_left > 0) begin
            m_init_left--;
            if (m_init_left == 0) m_ready = 1'b1;
        end
        m_upd_ready = m_ready && !uacc;
    endtask

    task automatic assert_reset();
        rst_n          = 1'b0;
        bus.pred_valid = 1'b0;
        bus.pred_index = 8'd0;
        bus.upd_valid  = 1'b0;
        bus.upd_index  = 8'd0;
        bus.upd_taken  = 1'b0;
        m_ready        = 1'b0;
        m_upd_ready    = 1'b0;
        exp_rv         = 1'b0;
        m_init_left    = 256;
        foreach (model[i]) model[i] = 1;
        #3;
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        int n;
        assert_reset();
        checks++;
        if ({bus.pred_ready, bus.upd_ready, bus.init_done, bus.pred_resp_valid, bus.pred_taken, bus.pred_counter} !== 7'b0) begin
            errors++;
            $display("FAIL reset_outputs got %b want 0000000", {bus.pred_ready, bus.upd_ready, bus.init_done, bus.pred_resp_valid, bus.pred_taken, bus.pred_counter});
        end
        release_reset();
        n = 0;
        while (n < 400) begin
            drive(1'b0, 0, 1'b0, 0, 1'b0);
            n++;
            checks++;
            if (bus.init_done !== m_ready) begin
                errors++;
                $display("FAIL init_done_cycle n=%0d got %b want %b", n, bus.init_done, m_ready);
            end
            if (bus.init_done === 1'b1) break;
        end
        checks++;
        if (n !== 256) begin
            errors++;
            $display("FAIL init_length got %0d want 256", n);
        end
        checks++;
        if ({bus.pred_ready, bus.upd_ready} !== 2'b11) begin
            errors++;
            $display("FAIL ready_after_init got %b want 11", {bus.pred_ready, bus.upd_ready});
        end
    endtask

    task automatic test_init_sweep();
        for (int i = 0; i < 256; i++) begin
            drive(1'b1, i, 1'b0, 0, 1'b0);
            checks++;
            if (bus.pred_resp_valid !== 1'b1 || bus.pred_counter !== 2'b01 || bus.pred_taken !== 1'b0 || exp_ctr !== 2'b01) begin
                errors++;
                $display("FAIL sweep_read idx=%0d got v=%b ctr=%b tk=%b want v=1 ctr=01 tk=0", i, bus.pred_resp_valid, bus.pred_counter, bus.pred_taken);
            end
        end
    endtask

    task automatic test_saturate();
        logic [1:0] want [2];
        want[0] = 2'b11;
        want[1] = 2'b00;
        for (int p = 0; p < 2; p++) begin
            for (int k = 0; k < 4 + p; k++) begin
                drive(1'b0, 0, 1'b1, 5, (p == 0));
                drive(1'b0, 0, 1'b0, 0, 1'b0);
            end
            drive(1'b1, 5, 1'b0, 0, 1'b0);
            checks++;
            if (bus.pred_resp_valid !== 1'b1 || bus.pred_counter !== want[p] || bus.pred_taken !== want[p][1]) begin
                errors++;
                $display("FAIL saturate phase=%0d got v=%b ctr=%b tk=%b want ctr=%b", p, bus.pred_resp_valid, bus.pred_counter, bus.pred_taken, want[p]);
            end
        end
    endtask

    task automatic test_forwarding();
        logic [1:0] want [3];
        want[0] = 2'b01;
        want[1] = 2'b10;
        want[2] = 2'b10;
        for (int j = 0; j < 3; j++) begin
            drive(1'b1, 9, (j == 0), 9, 1'b1);
            checks++;
            if (bus.pred_resp_valid !== 1'b1 || bus.pred_counter !== want[j]) begin
                errors++;
                $display("FAIL forward t+%0d got v=%b ctr=%b want ctr=%b", j, bus.pred_resp_valid, bus.pred_counter, want[j]);
            end
        end
    endtask

    task automatic test_back_to_back();
        bit want_rdy [3];
        want_rdy[0] = 1'b1;
        want_rdy[1] = 1'b0;
        want_rdy[2] = 1'b1;
        for (int j = 0; j < 3; j++) begin
            checks++;
            if (bus.upd_ready !== want_rdy[j]) begin
                errors++;
                $display("FAIL b2b_ready step=%0d got %b want %b", j, bus.upd_ready, want_rdy[j]);
            end
            drive(1'b0, 0, 1'b1, 200, 1'b1);
        end
        drive(1'b1, 200, 1'b0, 0, 1'b0);
        checks++;
        if (bus.pred_resp_valid !== 1'b1 || bus.pred_counter !== 2'b11) begin
            errors++;
            $display("FAIL b2b_final got v=%b ctr=%b want ctr=11", bus.pred_resp_valid, bus.pred_counter);
        end
    endtask

    task automatic test_concurrent();
        int acc0;
        acc0 = n_upd_acc;
        for (int j = 0; j < 20; j++) begin
            checks++;
            if (bus.upd_ready !== m_upd_ready) begin
                errors++;
                $display("FAIL conc_ready cyc=%0d got %b want %b", j, bus.upd_ready, m_upd_ready);
            end
            drive(1'b1, 3, 1'b1, 4, 1'b1);
            checks++;
            if (bus.pred_resp_valid !== 1'b1 || bus.pred_counter !== 2'b01) begin
                errors++;
                $display("FAIL conc_idx3 cyc=%0d got v=%b ctr=%b want ctr=01", j, bus.pred_resp_valid, bus.pred_counter);
            end
        end
        checks++;
        if (n_upd_acc - acc0 !== 10) begin
            errors++;
            $display("FAIL conc_accepts got %0d want 10", n_upd_acc - acc0);
        end
        drive(1'b1, 4, 1'b0, 0, 1'b0);
        checks++;
        if (bus.pred_counter !== 2'b11) begin
            errors++;
            $display("FAIL conc_idx4 got %b want 11", bus.pred_counter);
        end
    endtask

    task automatic test_random();
        for (int j = 0; j < 400; j++) begin
            checks++;
            if (bus.upd_ready !== m_upd_ready) begin
                errors++;
                $display("FAIL rand_ready cyc=%0d got %b want %b", j, bus.upd_ready, m_upd_ready);
            end
            drive(1'($urandom_range(0, 1)), int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                  int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
            checks++;
            if (bus.pred_resp_valid !== exp_rv || (exp_rv && (bus.pred_counter !== exp_ctr || bus.pred_taken !== exp_ctr[1]))) begin
                errors++;
                $display("FAIL rand_resp cyc=%0d got v=%b ctr=%b tk=%b want v=%b ctr=%b", j, bus.pred_resp_valid, bus.pred_counter, bus.pred_taken, exp_rv, exp_ctr);
            end
        end
    endtask

    task automatic test_reset_mid();
        int n;
        drive(1'b1, 4, 1'b1, 4, 1'b1);
        assert_reset();
        checks++;
        if ({bus.pred_ready, bus.upd_ready, bus.init_done, bus.pred_resp_valid, bus.pred_taken, bus.pred_counter} !== 7'b0) begin
            errors++;
            $display("FAIL async_reset got %b want 0000000", {bus.pred_ready, bus.upd_ready, bus.init_done, bus.pred_resp_valid, bus.pred_taken, bus.pred_counter});
        end
        release_reset();
        for (int j = 0; j < 100; j++) begin
            drive(1'b1, j, 1'b1, j, 1'b1);
            checks++;
            if (bus.pred_resp_valid !== 1'b0 || bus.init_done !== 1'b0 || bus.upd_ready !== 1'b0) begin
                errors++;
                $display("FAIL init_blocks cyc=%0d got v=%b done=%b urdy=%b want 0 0 0", j, bus.pred_resp_valid, bus.init_done, bus.upd_ready);
            end
        end
        assert_reset();
        checks++;
        if (bus.init_done !== 1'b0 || bus.pred_ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_sweep_reset got done=%b prdy=%b want 0 0", bus.init_done, bus.pred_ready);
        end
        release_reset();
        n = 0;
        while (n < 400) begin
            drive(1'b0, 0, 1'b0, 0, 1'b0);
            n++;
            if (bus.init_done === 1'b1) break;
        end
        checks++;
        if (n !== 256) begin
            errors++;
            $display("FAIL reinit_length got %0d want 256", n);
        end
        test_init_sweep();
    endtask

    initial begin
        n_upd_acc = 0;
        test_reset();
        test_init_sweep();
        test_saturate();
        test_forwarding();
        test_back_to_back();
        test_concurrent();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
